qsys_multi_interval_timer: RTL
==============================

Name: qsys_multi_interval_timer

Overview:
Parametrised successor to the team's single-channel Avalon-MM interval timer. Provides NUM_CH independent down-counters of COUNTER_WIDTH bits behind one 32-bit Avalon-MM slave. Each channel has one-shot/continuous mode, a snapshot register and an interrupt enable. Sits on the Qsys system bus; drives a per-channel IRQ vector and one aggregated CPU IRQ.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
COUNTER_WIDTH, 32, counter/period width in bits (8..32)
DEFAULT_PERIOD, 32'h005F5E0F, reset value of every period register and counter (truncated to COUNTER_WIDTH)

Ports:
clk  in  1  system clock; the only clock in the block
reset  in  1  synchronous, active-high reset
address  in  clog2(NUM_CH)+3  word address, {channel, reg_offset[2:0]}
chipselect  in  1  slave select
write  in  1  write strobe, qualified by chipselect
read  in  1  read strobe, qualified by chipselect
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  1  OR of irq_vec
irq_vec  out  NUM_CH  per-channel interrupt (timeout_occurred & ito)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all counters and periods = DEFAULT_PERIOD; control = 0; running = 0; timeout_occurred = 0; snapshot = 0; readdata = 0; irq = 0; irq_vec = 0.
- Per-channel register offsets:
  - 0 STATUS: {running, TO}. A write of any value clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. Bits [3:0] are stored.
  - 2 PERIOD.
  - 3 SNAP: a write captures the live counter; a read returns the captured value.
  - 4 PRESCALE: optional feature only.
  - 5-7: reserved. Read 0, writes ignored.
- Widths: PERIOD and SNAP read zero-extended to 32 bits; writes take writedata[COUNTER_WIDTH-1:0].
- Read timing: readdata updates on the clock edge following a cycle with chipselect & read. It holds its value otherwise. Latency is 1.
- Period write:
  - The period register updates at the edge of the write.
  - force_reload is asserted the next cycle.
  - At that edge the counter loads the period and running clears.
- Counter: while running, it decrements once per tick (every cycle without the optional feature).
  - On reaching 0 with CONT=1, it reloads the period on the next tick.
  - On reaching 0 with CONT=0, running clears and the counter holds 0.
- Timeout event: a rising edge of (counter==0), detected against a one-cycle-delayed copy. It sets TO.
- Simultaneous events:
  - START and STOP in the same write: START wins.
  - STATUS write and timeout event in the same cycle: TO is set (the event is not lost).
  - START and counter==0 in one-shot mode in the same cycle: START wins.
- Period 0: the counter stays 0. Exactly one timeout event occurs on entry to 0, and no further events until a non-zero reload.
- Channels are fully independent; a write to one channel never affects another.
- Reset asserted mid-count: all state returns to reset values at that edge; an in-flight read returns 0.

Optional Feature:
Macro TIMER_PRESCALER_EN.
- Defined:
  - Each channel gains a 16-bit PRESCALE register (offset 4, reset 0).
  - A prescale counter generates a tick every PRESCALE+1 cycles while running.
  - The prescale counter clears on START, on force_reload and on reset.
- Undefined:
  - Tick = 1 every cycle.
  - Offset 4 is reserved (reads 0).
  - No prescale logic is synthesised.

Decomposition:
- Package qsys_timer_pkg:
  - register offset constants (STATUS, CONTROL, PERIOD, SNAP, PRESCALE)
  - CONTROL bit indices (ITO, CONT, START, STOP) and STATUS bit indices (TO, RUN)
  - channel-select address width function
- Sub-module qsys_timer_channel: counter, control, status, snapshot and prescaler for one channel; instantiated NUM_CH times via generate.
- Top level: address decode, read mux/register, IRQ OR.

Test Plan:
1. Reset, then read ch0 PERIOD -> readdata = 0x005F5E0F one cycle after read; irq = 0; STATUS = 0.
2. ch1: write PERIOD = 5, CONTROL = 0x7 (START|CONT|ITO) -> TO sets every 6 ticks; irq_vec[1] = 1 and irq = 1; STATUS write clears TO and irq next cycle.
3. ch2: PERIOD = 3, CONTROL = 0x5 (one-shot) -> single timeout; STATUS reads 0x1 (TO=1, running=0); counter holds 0.
4. ch0 running: write SNAP -> read SNAP equals the live counter value at the write edge; ch3 counter is unaffected.
5. Write a STATUS clear in the same cycle as the timeout edge -> TO = 1. CONTROL write 0xC (START|STOP) -> running = 1.
6. With TIMER_PRESCALER_EN: PRESCALE = 3, PERIOD = 2, START|CONT -> timeout every 12 cycles. Assert reset mid-count -> every output returns to its reset value.

Source files
------------

// File: rtl/qsys_multi_interval_timer_pkg.sv
// Shared constants for the multi-channel interval timer: register offsets,
// CONTROL/STATUS bit positions and address-width helpers.
package qsys_timer_pkg;

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_CONTROL  = 3'd1;
  localparam logic [2:0] OFF_PERIOD   = 3'd2;
  localparam logic [2:0] OFF_SNAP     = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  function automatic int ch_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 0;
  endfunction

  // Word address = {channel, reg_offset[2:0]}
  function automatic int addr_w(input int num_ch);
    return ch_sel_w(num_ch) + 3;
  endfunction

endpackage

// File: rtl/qsys_multi_interval_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
interface qsys_multi_interval_timer_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write;
  logic              read;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output address, chipselect, write, read, writedata, input readdata);
  modport slave  (input address, chipselect, write, read, writedata, output readdata);
endinterface

// File: rtl/qsys_multi_interval_timer_channel.sv
// One timer channel: down-counter, control/status, snapshot and, when
// TIMER_PRESCALER_EN is defined, a 16-bit tick prescaler.
module qsys_timer_channel
  import qsys_timer_pkg::*;
#(
  parameter int          COUNTER_WIDTH  = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h005F5E0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  offset,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  localparam logic [COUNTER_WIDTH-1:0] RST_PERIOD = DEFAULT_PERIOD[COUNTER_WIDTH-1:0];

  logic [COUNTER_WIDTH-1:0] period_q, period_d, count_q, count_d, snap_q, snap_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic running_q, running_d, to_q, to_d, zero_d1_q, force_reload_q;
  logic wr_status, wr_ctrl, wr_period, wr_snap, start, stop, tick, zero, tmo_evt;
  logic unused_wdata;

  assign unused_wdata = ^wdata;
  assign wr_status = wr_en & (offset == OFF_STATUS);
  assign wr_ctrl   = wr_en & (offset == OFF_CONTROL);
  assign wr_period = wr_en & (offset == OFF_PERIOD);
  assign wr_snap   = wr_en & (offset == OFF_SNAP);
  assign start     = wr_ctrl & wdata[CTRL_START];
  assign stop      = wr_ctrl & wdata[CTRL_STOP];
  assign zero      = (count_q == '0);
  assign tmo_evt   = zero & ~zero_d1_q;

`ifdef TIMER_PRESCALER_EN
  logic [15:0] presc_q, presc_d, pcnt_q, pcnt_d;

  assign tick = running_q & (pcnt_q == presc_q);

  always_comb begin
    presc_d = (wr_en && offset == OFF_PRESCALE) ? wdata[15:0] : presc_q;
    pcnt_d  = pcnt_q;
    if (start || force_reload_q) pcnt_d = '0;
    else if (running_q)          pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick = running_q;
`endif

  always_comb begin
    period_d  = wr_period ? wdata[COUNTER_WIDTH-1:0] : period_q;
    snap_d    = wr_snap ? count_q : snap_q;
    ctrl_d    = wr_ctrl ? wdata[3:0] : ctrl_q;
    count_d   = count_q;
    running_d = running_q;
    if (force_reload_q) begin
      count_d   = period_q;
      running_d = 1'b0;
    end else if (tick) begin
      // At zero the tick either reloads (continuous) or stops (one-shot)
      if (!zero)                count_d   = count_q - COUNTER_WIDTH'(1);
      else if (ctrl_q[CTRL_CONT]) count_d = period_q;
      else                      running_d = 1'b0;
    end
    if (start)     running_d = 1'b1;
    else if (stop) running_d = 1'b0;
    to_d = tmo_evt | (to_q & ~wr_status);
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_STATUS: begin
        rdata[STAT_TO]  = to_q;
        rdata[STAT_RUN] = running_q;
      end
      OFF_CONTROL: rdata[3:0] = ctrl_q;
      OFF_PERIOD:  rdata[COUNTER_WIDTH-1:0] = period_q;
      OFF_SNAP:    rdata[COUNTER_WIDTH-1:0] = snap_q;
`ifdef TIMER_PRESCALER_EN
      OFF_PRESCALE: rdata[15:0] = presc_q;
`endif
      default: ;
    endcase
  end

  assign irq = to_q & ctrl_q[CTRL_ITO];

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q       <= RST_PERIOD;
      count_q        <= RST_PERIOD;
      snap_q         <= '0;
      ctrl_q         <= '0;
      running_q      <= 1'b0;
      to_q           <= 1'b0;
      zero_d1_q      <= 1'b0;
      force_reload_q <= 1'b0;
    end else begin
      period_q       <= period_d;
      count_q        <= count_d;
      snap_q         <= snap_d;
      ctrl_q         <= ctrl_d;
      running_q      <= running_d;
      to_q           <= to_d;
      zero_d1_q      <= zero;
      force_reload_q <= wr_period;
    end
  end

endmodule

// File: rtl/qsys_multi_interval_timer.sv
// NUM_CH independent interval timers behind one Avalon-MM slave: address
// decode, registered read mux and IRQ aggregation.
module qsys_multi_interval_timer
  import qsys_timer_pkg::*;
#(
  parameter int          NUM_CH         = 4,
  parameter int          COUNTER_WIDTH  = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h005F5E0F
) (
  input  logic                      clk,
  input  logic                      reset,
  qsys_multi_interval_timer_if.slave bus,
  output logic                      irq,
  output logic [NUM_CH-1:0]         irq_vec
);
  localparam int AW = addr_w(NUM_CH);

  logic [AW-1:0]             ch_addr;
  logic [NUM_CH-1:0]         sel, wr_en;
  logic [NUM_CH-1:0][31:0]   ch_rdata;
  logic [31:0]               readdata_q, readdata_d;

  assign ch_addr = bus.address >> 3;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign sel[c]   = (ch_addr == AW'(c));
    assign wr_en[c] = bus.chipselect & bus.write & sel[c];

    qsys_timer_channel #(
      .COUNTER_WIDTH  (COUNTER_WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_en[c]),
      .offset (bus.address[2:0]),
      .wdata  (bus.writedata),
      .rdata  (ch_rdata[c]),
      .irq    (irq_vec[c])
    );
  end

  // Unmapped channel numbers read as zero
  always_comb begin
    readdata_d = readdata_q;
    if (bus.chipselect && bus.read) begin
      readdata_d = '0;
      for (int c = 0; c < NUM_CH; c++)
        if (sel[c]) readdata_d = ch_rdata[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign bus.readdata = readdata_q;
  assign irq          = |irq_vec;

endmodule
